// File: rtl/alarm_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alarm_sequencer_pkg
// Shared definitions for the alarm path: FSM state encoding, default
// parameter values and a small saturating-increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package alarm_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_ARMED    = 3'd1,
        ST_RINGING  = 3'd2,
        ST_SNOOZE   = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam int DEF_SNOOZE_MIN       = 5;
    localparam int DEF_RING_TIMEOUT_MIN = 10;
    localparam int DEF_MAX_SNOOZE       = 3;
    localparam int DEF_BEEP_ON          = 4;
    localparam int DEF_BEEP_OFF         = 4;

    // 4-bit increment that holds at 15 instead of wrapping to 0.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/alarm_sequencer_beep_envelope.sv
// -----------------------------------------------------------------------------
// alarm_sequencer_beep_envelope
// Beep phase counter and buzzer envelope decode. While en is high the counter
// advances on every tick_beep pulse, modulo BEEP_ON+BEEP_OFF; sonido is high
// for the first BEEP_ON phases of each period. While en is low the counter is
// held at 0 so every ring starts with a fresh "on" phase.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   en        in  envelope enable (alarm is in RINGING)
//   tick_beep in  one-cycle beep cadence pulse
//   sonido    out registered buzzer enable
// -----------------------------------------------------------------------------
module alarm_sequencer_beep_envelope
    import alarm_sequencer_pkg::*;
#(
    parameter int BEEP_ON  = DEF_BEEP_ON,
    parameter int BEEP_OFF = DEF_BEEP_OFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic tick_beep,
    output logic sonido
);

    localparam int PERIOD = BEEP_ON + BEEP_OFF;
    // The counter is only 4 bits: a period longer than 16 is clamped so the
    // counter restarts from 15 rather than wrapping through 0 on its own.
    localparam int LAST   = (PERIOD > 16) ? 15 : PERIOD - 1;

    logic [3:0] cnt_q, cnt_d;
    logic       sonido_q;

    always_comb begin
        cnt_d = cnt_q;
        if (tick_beep) begin
            cnt_d = (cnt_q == 4'(LAST)) ? 4'd0 : cnt_q + 4'd1;
        end
    end

    // sonido is decoded from the next count so the envelope edge lines up
    // with the tick_beep edge that moved the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            sonido_q <= 1'b0;
        end else if (en) begin
            cnt_q    <= cnt_d;
            sonido_q <= (cnt_d < 4'(BEEP_ON));
        end else begin
            cnt_q    <= 4'd0;
            sonido_q <= 1'b0;
        end
    end

    assign sonido = sonido_q;

endmodule

// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
// Alarm path of the clock: compares running time against the alarm time
// (BCD), fires once per matching minute, and handles ring / snooze / timeout
// / off. Drives the buzzer envelope through the beep_envelope sub-block.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tick_min            one-cycle pulse per minute
//   tick_beep           one-cycle beep cadence pulse
//   arm_en              alarm enabled (level); low forces DISARMED
//   edit                setting in progress (level); masks the match
//   off_p, snooze_p     one-cycle user requests
//   t_digits, a_digits  running time / alarm time, BCD {h3,h2,m1,m0}
//   sonido              buzzer enable envelope
//   ringing, snoozing   registered decodes of RINGING / SNOOZE
//   snooze_cnt          snoozes used in the current alarm event
//   state_dbg           current FSM state (debug observation)
// -----------------------------------------------------------------------------
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int SNOOZE_MIN       = DEF_SNOOZE_MIN,
    parameter int RING_TIMEOUT_MIN = DEF_RING_TIMEOUT_MIN,
    parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE,
    parameter int BEEP_ON          = DEF_BEEP_ON,
    parameter int BEEP_OFF         = DEF_BEEP_OFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_min,
    input  logic        tick_beep,
    input  logic        arm_en,
    input  logic        edit,
    input  logic        off_p,
    input  logic        snooze_p,
    input  logic [15:0] t_digits,
    input  logic [15:0] a_digits,
    output logic        sonido,
    output logic        ringing,
    output logic        snoozing,
    output logic [1:0]  snooze_cnt,
    output logic [2:0]  state_dbg
);

    state_e     state_q, state_d;
    logic [3:0] min_q, min_d, min_inc;
    logic [1:0] snz_q, snz_d;
    logic       match, match_q, rise;
    logic       ringing_q, snoozing_q;

    // Only a fresh match fires, so an alarm rings once per matching minute
    // and a match that appears when edit drops still counts as an edge.
    assign match = (t_digits == a_digits) & ~edit;
    assign rise  = match & ~match_q;

    always_comb begin
        min_inc = sat_inc4(min_q);
        state_d = state_q;
        min_d   = min_q;
        snz_d   = snz_q;
        if (!arm_en) begin
            state_d = ST_DISARMED;
            min_d   = 4'd0;
            snz_d   = 2'd0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    state_d = ST_ARMED;
                    min_d   = 4'd0;
                    snz_d   = 2'd0;
                end
                ST_ARMED: begin
                    if (rise) begin
                        state_d = ST_RINGING;
                        min_d   = 4'd0;
                    end
                end
                ST_RINGING: begin
                    if (off_p) begin
                        state_d = ST_DONE;
                        min_d   = 4'd0;
                        snz_d   = 2'd0;
                    end else if (snooze_p && (snz_q < 2'(MAX_SNOOZE))) begin
                        state_d = ST_SNOOZE;
                        min_d   = 4'd0;
                        snz_d   = snz_q + 2'd1;
                    end else if (tick_min) begin
                        // An exhausted snooze request falls through here,
                        // so it cannot hold off the ring timeout.
                        min_d = min_inc;
                        if (min_inc == 4'(RING_TIMEOUT_MIN)) begin
                            state_d = ST_DONE;
                            min_d   = 4'd0;
                            snz_d   = 2'd0;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (off_p) begin
                        state_d = ST_DONE;
                        min_d   = 4'd0;
                        snz_d   = 2'd0;
                    end else if (tick_min) begin
                        min_d = min_inc;
                        if (min_inc == 4'(SNOOZE_MIN)) begin
                            state_d = ST_RINGING;
                            min_d   = 4'd0;
                        end
                    end
                end
                ST_DONE: begin
                    if (!match) begin
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    min_d   = 4'd0;
                    snz_d   = 2'd0;
                end
            endcase
        end
    end

    // ringing/snoozing decode the next state so they are valid right after
    // the transition edge rather than one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_DISARMED;
            min_q      <= 4'd0;
            snz_q      <= 2'd0;
            match_q    <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            snz_q      <= snz_d;
            match_q    <= match;
            ringing_q  <= (state_d == ST_RINGING);
            snoozing_q <= (state_d == ST_SNOOZE);
        end
    end

    alarm_sequencer_beep_envelope #(
        .BEEP_ON  (BEEP_ON),
        .BEEP_OFF (BEEP_OFF)
    ) u_beep (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == ST_RINGING),
        .tick_beep (tick_beep),
        .sonido    (sonido)
    );

    assign ringing    = ringing_q;
    assign snoozing   = snoozing_q;
    assign snooze_cnt = snz_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
module tb_alarm_sequencer;

  localparam logic [15:0] ALARM = 16'h0700;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tick_min, tick_beep, arm_en, edit, off_p, snooze_p;
  logic [15:0] t_digits, a_digits;
  logic        sonido, ringing, snoozing;
  logic [1:0]  snooze_cnt;
  logic [2:0]  state_dbg;

  alarm_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_min   (tick_min),
    .tick_beep  (tick_beep),
    .arm_en     (arm_en),
    .edit       (edit),
    .off_p      (off_p),
    .snooze_p   (snooze_p),
    .t_digits   (t_digits),
    .a_digits   (a_digits),
    .sonido     (sonido),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // expected word: {check_sonido, state[2:0], ringing, snoozing, snooze_cnt[1:0], sonido}
  logic [8:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [8:0] mk_exp(input logic [2:0] st, input logic r, input logic s,
                                        input logic [1:0] c, input logic chk, input logic son);
    return {chk, st, r, s, c, son};
  endfunction

  task automatic check(input string name);
    logic [8:0] e;
    logic [7:0] got;
    logic       bad;
    e   = exp_q.pop_front();
    got = {state_dbg, ringing, snoozing, snooze_cnt, sonido};
    bad = (got[7:1] != e[7:1]) || (e[8] && (got[0] != e[0]));
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got state=%0d ring=%0b snz=%0b cnt=%0d son=%0b, expected state=%0d ring=%0b snz=%0b cnt=%0d son=%0b%s",
               name, got[7:5], got[4], got[3], got[2:1], got[0],
               e[7:5], e[4], e[3], e[2:1], e[0], e[8] ? "" : "(don't care)");
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string name, input logic tm, input logic tb, input logic off,
                      input logic snz, input logic [15:0] t, input logic [8:0] e);
    @(negedge clk);
    tick_min  = tm;
    tick_beep = tb;
    off_p     = off;
    snooze_p  = snz;
    t_digits  = t;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        tm, tb, off, snz;
    logic [15:0] t;
    logic [8:0]  e;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic tm, input logic tb, input logic off,
                     input logic snz, input logic [15:0] t, input logic [8:0] e);
    vec_t v;
    v.name = name; v.tm = tm; v.tb = tb; v.off = off; v.snz = snz; v.t = t; v.e = e;
    tbl.push_back(v);
  endtask

  // beep phase pattern over 8 tick_beep pulses: 4 on, 4 off, back on
  logic beep_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    tick_min = 0; tick_beep = 0; arm_en = 0; edit = 0; off_p = 0; snooze_p = 0;
    t_digits = 16'h0659; a_digits = ALARM;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk_exp(3'd0, 0, 0, 2'd0, 1, 0));
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    arm_en = 1'b1;

    // ---- table: ring on match, beep envelope, ring timeout ----
    add("arm",         0, 0, 0, 0, 16'h0659, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));
    add("armed_hold",  0, 0, 0, 0, 16'h0659, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));
    add("match_rise",  0, 0, 0, 0, ALARM,    mk_exp(3'd2, 1, 0, 2'd0, 0, 0));
    add("sonido_on",   0, 0, 0, 0, ALARM,    mk_exp(3'd2, 1, 0, 2'd0, 1, 1));
    for (int i = 0; i < 8; i++)
      add($sformatf("beep_tick%0d", i + 1), 0, 1, 0, 0, ALARM, mk_exp(3'd2, 1, 0, 2'd0, 1, beep_exp[i]));
    add("beep_hold",   0, 0, 0, 0, ALARM,    mk_exp(3'd2, 1, 0, 2'd0, 1, 1));
    for (int i = 1; i < 10; i++)
      add($sformatf("ring_min%0d", i), 1, 0, 0, 0, ALARM, mk_exp(3'd2, 1, 0, 2'd0, 1, 1));
    add("ring_timeout",   1, 0, 0, 0, ALARM,    mk_exp(3'd4, 0, 0, 2'd0, 0, 0));
    add("done_quiet",     0, 0, 0, 0, ALARM,    mk_exp(3'd4, 0, 0, 2'd0, 1, 0));
    add("done_no_rering", 0, 0, 0, 0, ALARM,    mk_exp(3'd4, 0, 0, 2'd0, 1, 0));
    add("done_to_armed",  0, 0, 0, 0, 16'h0701, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));
    foreach (tbl[i]) step(tbl[i].name, tbl[i].tm, tbl[i].tb, tbl[i].off, tbl[i].snz, tbl[i].t, tbl[i].e);

    // ---- snooze cycles up to MAX_SNOOZE, then an ignored snooze ----
    step("rering_rise", 0, 0, 0, 0, ALARM, mk_exp(3'd2, 1, 0, 2'd0, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 2; j++)
        step($sformatf("ring_pre_snooze%0d", k), 1, 0, 0, 0, ALARM, mk_exp(3'd2, 1, 0, 2'(k - 1), 0, 0));
      step($sformatf("snooze%0d", k), 0, 0, 0, 1, ALARM, mk_exp(3'd3, 0, 1, 2'(k), 0, 0));
      for (int i = 1; i <= 5; i++) begin
        if (i < 5)
          step($sformatf("snooze%0d_min%0d", k, i), 1, 0, 0, 0, ALARM, mk_exp(3'd3, 0, 1, 2'(k), 1, 0));
        else
          step($sformatf("snooze%0d_rering", k), 1, 0, 0, 0, ALARM, mk_exp(3'd2, 1, 0, 2'(k), 1, 0));
      end
    end
    step("snooze4_ignored", 0, 0, 0, 1, ALARM, mk_exp(3'd2, 1, 0, 2'd3, 0, 0));
    step("still_ringing",   0, 0, 0, 0, ALARM, mk_exp(3'd2, 1, 0, 2'd3, 1, 1));

    // ---- off and snooze together: off wins, count cleared ----
    step("off_beats_snooze", 0, 0, 1, 1, ALARM,    mk_exp(3'd4, 0, 0, 2'd0, 0, 0));
    step("done_hold_match",  0, 0, 0, 0, ALARM,    mk_exp(3'd4, 0, 0, 2'd0, 1, 0));
    step("done_rearm",       0, 0, 0, 0, 16'h0701, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));

    // ---- edit masks the match until it drops ----
    edit = 1'b1;
    step("edit_masked1", 0, 0, 0, 0, ALARM, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));
    step("edit_masked2", 0, 0, 0, 0, ALARM, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));
    edit = 1'b0;
    step("edit_release_ring", 0, 0, 0, 0, ALARM, mk_exp(3'd2, 1, 0, 2'd0, 0, 0));

    // ---- arm_en=0 mid-snooze overrides a simultaneous off ----
    step("snooze_then_disarm", 0, 0, 0, 1, ALARM, mk_exp(3'd3, 0, 1, 2'd1, 0, 0));
    step("snooze_min1",        1, 0, 0, 0, ALARM, mk_exp(3'd3, 0, 1, 2'd1, 1, 0));
    arm_en = 1'b0;
    step("disarm_override",    0, 0, 1, 0, ALARM, mk_exp(3'd0, 0, 0, 2'd0, 1, 0));
    step("disarmed_hold",      1, 1, 0, 1, ALARM, mk_exp(3'd0, 0, 0, 2'd0, 1, 0));
    arm_en = 1'b1;
    step("rearm_level_match",  0, 0, 0, 0, ALARM, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));
    step("no_ring_on_level",   0, 0, 0, 0, ALARM, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));

    // ---- async reset while ringing ----
    step("leave_match",  0, 0, 0, 0, 16'h0701, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));
    step("ring_again",   0, 0, 0, 0, ALARM,    mk_exp(3'd2, 1, 0, 2'd0, 0, 0));
    step("ring_sonido",  0, 0, 0, 0, ALARM,    mk_exp(3'd2, 1, 0, 2'd0, 1, 1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk_exp(3'd0, 0, 0, 2'd0, 1, 0));
    check("async_reset_now");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_arm",     0, 0, 0, 0, ALARM, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));
    step("post_reset_no_ring", 0, 0, 0, 0, ALARM, mk_exp(3'd1, 0, 0, 2'd0, 1, 0));

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
